// File: rtl/pcie_msg_fetch_if.sv
// Bus bundle for pcie_msg_fetch: event input, SRAM read port, outbound beat stream and status.
// master = fetch engine side, slave = surrounding logic (receiver, SRAM, consumer).
interface pcie_msg_fetch_if;
  logic         evt_valid;
  logic [3:0]   evt_tag;
  logic [9:0]   evt_addr;
  logic [11:0]  evt_len;
  logic         sram_ren;
  logic [9:0]   sram_raddr;
  logic [255:0] sram_rdata;
  logic         o_valid;
  logic [255:0] o_data;
  logic [3:0]   o_tag;
  logic         o_first;
  logic         o_last;
  logic         i_ready;
  logic [7:0]   o_err_cnt;
  logic         o_busy;

  modport master (
    input  evt_valid, evt_tag, evt_addr, evt_len, sram_rdata, i_ready,
    output sram_ren, sram_raddr, o_valid, o_data, o_tag, o_first, o_last, o_err_cnt, o_busy
  );

  modport slave (
    output evt_valid, evt_tag, evt_addr, evt_len, sram_rdata, i_ready,
    input  sram_ren, sram_raddr, o_valid, o_data, o_tag, o_first, o_last, o_err_cnt, o_busy
  );
endinterface

// File: rtl/pcie_msg_fetch.sv
// Queues assembled-message descriptors and streams each message's beats out of SRAM in order.
// Optional macro PCIE_MSG_FETCH_TAG_CHECK_EN rejects events whose tag is already queued or in progress.
module pcie_msg_fetch #(
  parameter int          DESC_DEPTH = 4,
  parameter logic [11:0] MAX_LEN    = 12'd1024
) (
  input logic              clk,
  input logic              rst,
  pcie_msg_fetch_if.master bus
);

  localparam int DATA_W = 256;
  localparam int AW     = $clog2(DESC_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [3:0]        fifo_tag  [DESC_DEPTH];
  logic [9:0]        fifo_addr [DESC_DEPTH];
  logic [11:0]       fifo_len  [DESC_DEPTH];
  logic [AW:0]       wptr, rptr;
  logic              fifo_empty, fifo_full, fifo_pop;
  logic              len_bad, tag_dup, evt_accept, evt_reject;

  logic [1:0]        state;
  logic [9:0]        rd_addr;
  logic [11:0]       remaining;
  logic [3:0]        cur_tag;
  logic              first_pend;
  logic              issue;

  logic              vld_p1;
  logic [3:0]        tag_p1;
  logic              first_p1, last_p1;

  logic [DATA_W-1:0] buf_data  [2];
  logic [3:0]        buf_tag   [2];
  logic              buf_first [2];
  logic              buf_last  [2];
  logic              wsel, rsel;
  logic [1:0]        buf_cnt, buf_cnt_next;
  logic              bypass, buf_wr, buf_rd, out_vld, out_pop;
  logic [7:0]        err_cnt;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign fifo_pop   = (state == S_IDLE) && !fifo_empty;
  assign len_bad    = (bus.evt_len == 12'd0) || (bus.evt_len > MAX_LEN);

`ifdef PCIE_MSG_FETCH_TAG_CHECK_EN
  logic [AW:0] fifo_occ;
  assign fifo_occ = wptr - rptr;

  // Slot j is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    tag_dup = 1'b0;
    for (int j = 0; j < DESC_DEPTH; j++) begin
      if (({1'b0, AW'(AW'(j) - rptr[AW-1:0])} < fifo_occ) && (fifo_tag[j] == bus.evt_tag))
        tag_dup = 1'b1;
    end
    if ((state != S_IDLE) && (cur_tag == bus.evt_tag))
      tag_dup = 1'b1;
  end
`else
  assign tag_dup = 1'b0;
`endif

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign evt_accept = bus.evt_valid && !len_bad && !tag_dup && (!fifo_full || fifo_pop);
  assign evt_reject = bus.evt_valid && !evt_accept;

  // The returning beat falls straight through to the output when the buffer is empty.
  assign out_vld      = (buf_cnt != 2'd0) || vld_p1;
  assign out_pop      = out_vld && bus.i_ready;
  assign bypass       = vld_p1 && (buf_cnt == 2'd0);
  assign buf_wr       = vld_p1 && !(bypass && bus.i_ready);
  assign buf_rd       = out_pop && (buf_cnt != 2'd0);
  assign buf_cnt_next = buf_cnt + {1'b0, buf_wr} - {1'b0, buf_rd};
  assign issue        = (state == S_FETCH) && !rst && (buf_cnt_next < 2'd2);

  assign bus.sram_ren   = issue;
  assign bus.sram_raddr = issue ? rd_addr : 10'd0;
  assign bus.o_valid    = out_vld;
  assign bus.o_data     = (buf_cnt != 2'd0) ? buf_data[rsel]  : (vld_p1 ? bus.sram_rdata : '0);
  assign bus.o_tag      = (buf_cnt != 2'd0) ? buf_tag[rsel]   : (vld_p1 ? tag_p1 : 4'd0);
  assign bus.o_first    = (buf_cnt != 2'd0) ? buf_first[rsel] : (vld_p1 && first_p1);
  assign bus.o_last     = (buf_cnt != 2'd0) ? buf_last[rsel]  : (vld_p1 && last_p1);
  assign bus.o_err_cnt  = err_cnt;
  assign bus.o_busy     = !fifo_empty || (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      wptr    <= '0;
      rptr    <= '0;
      vld_p1  <= 1'b0;
      buf_cnt <= 2'd0;
      wsel    <= 1'b0;
      rsel    <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      if (evt_accept) wptr <= wptr + 1'b1;
      if (fifo_pop)   rptr <= rptr + 1'b1;
      vld_p1  <= issue;
      buf_cnt <= buf_cnt_next;
      if (buf_wr) wsel <= ~wsel;
      if (buf_rd) rsel <= ~rsel;
      if (evt_reject && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      case (state)
        S_IDLE:  if (fifo_pop) state <= S_FETCH;
        S_FETCH: if (issue && (remaining == 12'd1)) state <= S_DRAIN;
        S_DRAIN: if (buf_cnt_next == 2'd0) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // p0: descriptor storage and read-address generation
  always_ff @(posedge clk) begin
    if (evt_accept) begin
      fifo_tag[wptr[AW-1:0]]  <= bus.evt_tag;
      fifo_addr[wptr[AW-1:0]] <= bus.evt_addr;
      fifo_len[wptr[AW-1:0]]  <= bus.evt_len;
    end
    if (fifo_pop) begin
      rd_addr    <= fifo_addr[rptr[AW-1:0]];
      remaining  <= fifo_len[rptr[AW-1:0]];
      cur_tag    <= fifo_tag[rptr[AW-1:0]];
      first_pend <= 1'b1;
    end else if (issue) begin
      rd_addr    <= rd_addr + 10'd1;
      remaining  <= remaining - 12'd1;
      first_pend <= 1'b0;
    end
  end

  // p1: beat attributes travel with the outstanding SRAM read
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_p1   <= cur_tag;
      first_p1 <= first_pend;
      last_p1  <= (remaining == 12'd1);
    end
  end

  // p2: two-entry output buffer fed by the returning read
  always_ff @(posedge clk) begin
    if (buf_wr) begin
      buf_data[wsel]  <= bus.sram_rdata;
      buf_tag[wsel]   <= tag_p1;
      buf_first[wsel] <= first_p1;
      buf_last[wsel]  <= last_p1;
    end
  end

endmodule

// File: tb/tb_pcie_msg_fetch.sv
// Self-checking bench for pcie_msg_fetch: directed scenarios plus randomized bursts against a beat-queue model.
module tb_pcie_msg_fetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pcie_msg_fetch_if bus();

  pcie_msg_fetch #(.DESC_DEPTH(4), .MAX_LEN(12'd1024)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  logic [255:0] mem [1024];
  always @(posedge clk) if (bus.sram_ren) bus.sram_rdata <= mem[bus.sram_raddr];

  typedef struct packed {
    logic [255:0] data;
    logic [3:0]   tag;
    logic         first;
    logic         last;
  } beat_t;

  typedef struct {
    int          off;
    logic [3:0]  tag;
    logic [9:0]  addr;
    logic [11:0] len;
  } ev_t;

  ev_t   ev_q[$];
  beat_t got_q[$];
  beat_t exp_q[$];
  int    got_cyc[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    hold_viol;
  bit    busy_seen;

  function automatic void add_msg(input logic [3:0] tag, input logic [9:0] addr, input logic [11:0] len);
    beat_t b;
    for (int k = 0; k < int'(len); k++) begin
      b.data  = mem[10'((int'(addr) + k) % 1024)];
      b.tag   = tag;
      b.first = (k == 0);
      b.last  = (k == int'(len) - 1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic void push_ev(input int off, input logic [3:0] tag, input logic [9:0] addr, input logic [11:0] len);
    ev_t e;
    e.off = off; e.tag = tag; e.addr = addr; e.len = len;
    ev_q.push_back(e);
  endfunction

  function automatic void clear_q();
    ev_q.delete(); got_q.delete(); exp_q.delete(); got_cyc.delete();
    hold_viol = 0;
    busy_seen = 0;
  endfunction

  // Drives events and i_ready for ncyc cycles and records every transferred beat.
  task automatic collect(input int ncyc, input int mode);
    beat_t cur, held;
    bit    stalled;
    ev_t   e;
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      case (mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = (c % 4 == 0) || (c % 4 == 3);
        default: bus.i_ready = 1'($urandom_range(0, 1));
      endcase
      bus.evt_valid = 1'b0;
      if (ev_q.size() > 0 && ev_q[0].off == c) begin
        e = ev_q.pop_front();
        bus.evt_valid = 1'b1;
        bus.evt_tag   = e.tag;
        bus.evt_addr  = e.addr;
        bus.evt_len   = e.len;
      end
      #1;
      if (bus.o_busy) busy_seen = 1'b1;
      cur.data  = bus.o_data;
      cur.tag   = bus.o_tag;
      cur.first = bus.o_first;
      cur.last  = bus.o_last;
      if (stalled && (!bus.o_valid || cur !== held)) hold_viol++;
      if (bus.o_valid && bus.i_ready) begin
        got_q.push_back(cur);
        got_cyc.push_back(c);
      end
      stalled = bus.o_valid && !bus.i_ready;
      held    = cur;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.evt_valid = 1'b0;
    bus.i_ready   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_q();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_ready   = 1'b1;
    bus.evt_valid = 1'b1;
    bus.evt_tag   = 4'd7;
    bus.evt_addr  = 10'd5;
    bus.evt_len   = 12'd2;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid: got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_o_busy: got %b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", bus.o_err_cnt); end
    n_cmp++; if (bus.sram_ren !== 1'b0) begin n_bad++; $display("FAIL reset_sram_ren: got %b want 0", bus.sram_ren); end
    n_cmp++;
    if ({bus.sram_raddr, bus.o_data, bus.o_tag, bus.o_first, bus.o_last} !== '0) begin
      n_bad++;
      $display("FAIL reset_fields: got raddr=%h tag=%h first=%b last=%b data=%h want all 0",
               bus.sram_raddr, bus.o_tag, bus.o_first, bus.o_last, bus.o_data);
    end
    rst = 1'b0;
    bus.evt_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_evt_ignored: o_busy got %b want 0", bus.o_busy); end
    clear_q();
  endtask

  task automatic test_basic();
    clear_q();
    push_ev(0, 4'd3, 10'd10, 12'd4);
    add_msg(4'd3, 10'd10, 12'd4);
    collect(12, 0);
    n_cmp++; if (got_q.size() !== 4) begin n_bad++; $display("FAIL basic_count: got %0d want 4", got_q.size()); end
    n_cmp++; if (got_cyc.size() == 0 || got_cyc[0] !== 3) begin n_bad++; $display("FAIL basic_latency: got %0d want 3", got_cyc.size() ? got_cyc[0] : -1); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL basic_beat %0d: got tag=%h f=%b l=%b data=%h want tag=%h f=%b l=%b data=%h", i,
                 got_q[i].tag, got_q[i].first, got_q[i].last, got_q[i].data, exp_q[i].tag, exp_q[i].first, exp_q[i].last, exp_q[i].data);
      end
    end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: o_busy got %b want 0", bus.o_busy); end
  endtask

  task automatic test_wrap();
    clear_q();
    push_ev(0, 4'd8, 10'd1022, 12'd4);
    add_msg(4'd8, 10'd1022, 12'd4);
    collect(12, 0);
    n_cmp++; if (got_q.size() !== 4) begin n_bad++; $display("FAIL wrap_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL wrap_beat %0d: got data=%h want data=%h", i, got_q[i].data, exp_q[i].data);
      end
    end
  endtask

  task automatic test_stall();
    clear_q();
    push_ev(0, 4'd9, 10'd200, 12'd8);
    add_msg(4'd9, 10'd200, 12'd8);
    collect(45, 1);
    n_cmp++; if (got_q.size() !== 8) begin n_bad++; $display("FAIL stall_count: got %0d want 8", got_q.size()); end
    n_cmp++; if (hold_viol !== 0) begin n_bad++; $display("FAIL stall_hold: got %0d violations want 0", hold_viol); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL stall_beat %0d: got tag=%h f=%b l=%b data=%h want tag=%h f=%b l=%b data=%h", i,
                 got_q[i].tag, got_q[i].first, got_q[i].last, got_q[i].data, exp_q[i].tag, exp_q[i].first, exp_q[i].last, exp_q[i].data);
      end
    end
  endtask

  task automatic test_len_reject();
    do_reset();
    push_ev(0, 4'd1, 10'd0, 12'd0);
    push_ev(1, 4'd2, 10'd0, 12'd1025);
    collect(10, 0);
    n_cmp++; if (bus.o_err_cnt !== 8'd2) begin n_bad++; $display("FAIL len_reject_err: got %0d want 2", bus.o_err_cnt); end
    n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL len_reject_out: got %0d beats want 0", got_q.size()); end
    n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL len_reject_busy: got %b want 0", busy_seen); end
  endtask

  task automatic test_overflow();
    int gaps;
    do_reset();
    push_ev(0, 4'd0, 10'd100, 12'd20);
    add_msg(4'd0, 10'd100, 12'd20);
    for (int i = 1; i <= 6; i++) begin
      push_ev(3 + i, 4'(i), 10'(300 + 10 * i), 12'd2);
      if (i <= 4) add_msg(4'(i), 10'(300 + 10 * i), 12'd2);
    end
    collect(90, 0);
    n_cmp++; if (bus.o_err_cnt !== 8'd2) begin n_bad++; $display("FAIL overflow_err: got %0d want 2", bus.o_err_cnt); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL overflow_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL overflow_beat %0d: got tag=%h f=%b l=%b want tag=%h f=%b l=%b", i,
                 got_q[i].tag, got_q[i].first, got_q[i].last, exp_q[i].tag, exp_q[i].first, exp_q[i].last);
      end
    end
    gaps = 0;
    for (int i = 1; i < got_q.size(); i++)
      if (!got_q[i-1].last && got_cyc[i] != got_cyc[i-1] + 1) gaps++;
    n_cmp++; if (gaps !== 0) begin n_bad++; $display("FAIL overflow_gaps: got %0d gaps want 0", gaps); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_ev(0, 4'd6, 10'd500, 12'd6);
    push_ev(1, 4'd1, 10'd0, 12'd0);
    collect(5, 0);
    n_cmp++; if (got_q.size() !== 2) begin n_bad++; $display("FAIL reset_mid_pre: got %0d beats want 2", got_q.size()); end
    n_cmp++; if (bus.o_err_cnt !== 8'd1) begin n_bad++; $display("FAIL reset_mid_pre_err: got %0d want 1", bus.o_err_cnt); end
    @(negedge clk);
    rst = 1'b1;
    bus.evt_valid = 1'b1;
    bus.evt_tag   = 4'd11;
    bus.evt_addr  = 10'd0;
    bus.evt_len   = 12'd3;
    @(negedge clk);
    rst = 1'b0;
    bus.evt_valid = 1'b0;
    #1;
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mid_valid: got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_mid_err: got %0d want 0", bus.o_err_cnt); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid_busy: got %b want 0", bus.o_busy); end
    clear_q();
    push_ev(0, 4'd12, 10'd40, 12'd3);
    add_msg(4'd12, 10'd40, 12'd3);
    collect(12, 0);
    n_cmp++; if (got_q.size() !== 3) begin n_bad++; $display("FAIL reset_mid_fresh_count: got %0d want 3", got_q.size()); end
    n_cmp++; if (got_cyc.size() == 0 || got_cyc[0] !== 3) begin n_bad++; $display("FAIL reset_mid_fresh_latency: got %0d want 3", got_cyc.size() ? got_cyc[0] : -1); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL reset_mid_beat %0d: got tag=%h f=%b l=%b data=%h want tag=%h f=%b l=%b data=%h", i,
                 got_q[i].tag, got_q[i].first, got_q[i].last, got_q[i].data, exp_q[i].tag, exp_q[i].first, exp_q[i].last, exp_q[i].data);
      end
    end
  endtask

  task automatic test_tag_dup();
    int want_err;
    do_reset();
    push_ev(0, 4'd5, 10'd60, 12'd3);
    push_ev(1, 4'd5, 10'd70, 12'd2);
    add_msg(4'd5, 10'd60, 12'd3);
`ifdef PCIE_MSG_FETCH_TAG_CHECK_EN
    want_err = 1;
`else
    want_err = 0;
    add_msg(4'd5, 10'd70, 12'd2);
`endif
    collect(25, 0);
    n_cmp++; if (int'(bus.o_err_cnt) !== want_err) begin n_bad++; $display("FAIL tag_dup_err: got %0d want %0d", bus.o_err_cnt, want_err); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL tag_dup_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL tag_dup_beat %0d: got data=%h want data=%h", i, got_q[i].data, exp_q[i].data);
      end
    end
  endtask

  task automatic test_random();
    int model_err, n, sum_len, r;
    logic [11:0] len;
    logic [9:0]  addr;
    do_reset();
    model_err = 0;
    for (int b = 0; b < 20; b++) begin
      clear_q();
      n = $urandom_range(1, 4);
      sum_len = 0;
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      len = 12'd0;
        else if (r == 1) len = 12'(1025 + $urandom_range(0, 100));
        else             len = 12'($urandom_range(1, 12));
        addr = 10'($urandom_range(0, 1023));
        push_ev(i, 4'((b * 4 + i) % 16), addr, len);
        if (len >= 12'd1 && len <= 12'd1024) begin
          add_msg(4'((b * 4 + i) % 16), addr, len);
          sum_len += int'(len);
        end else begin
          model_err++;
        end
      end
      collect(30 + 4 * sum_len + 8 * n, 2);
      n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count b%0d: got %0d want %0d", b, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL rand_beat b%0d/%0d: got tag=%h f=%b l=%b want tag=%h f=%b l=%b", b, i,
                   got_q[i].tag, got_q[i].first, got_q[i].last, exp_q[i].tag, exp_q[i].first, exp_q[i].last);
        end
      end
      n_cmp++; if (hold_viol !== 0) begin n_bad++; $display("FAIL rand_hold b%0d: got %0d want 0", b, hold_viol); end
      n_cmp++; if (int'(bus.o_err_cnt) !== model_err) begin n_bad++; $display("FAIL rand_err b%0d: got %0d want %0d", b, bus.o_err_cnt, model_err); end
      n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL rand_idle b%0d: o_busy got %b want 0", b, bus.o_busy); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      for (int w = 0; w < 8; w++)
        mem[i][w*32 +: 32] = $urandom();
    bus.evt_valid = 1'b0;
    bus.evt_tag   = 4'd0;
    bus.evt_addr  = 10'd0;
    bus.evt_len   = 12'd0;
    bus.i_ready   = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_len_reject();
    test_overflow();
    test_reset_mid();
    test_tag_dup();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pcie_msg_fetch.md
PCIE_MSG_FETCH -- requirements
Module: pcie_msg_fetch

Interface
REQ-001 SHALL have parameter DESC_DEPTH, default 4, descriptor FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter MAX_LEN, default 12'd1024, maximum accepted message length in beats.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port evt_valid  input  1  single-cycle assembled-message event from receiver (no backpressure).
REQ-006 SHALL have port evt_tag  input  4  MSG_TAG of the assembled message.
REQ-007 SHALL have port evt_addr  input  10  SRAM beat address of the first beat.
REQ-008 SHALL have port evt_len  input  12  message length in 256-bit beats.
REQ-009 SHALL have ports sram_ren  output  1, sram_raddr  output  10, sram_rdata  input  256: SRAM read port; data valid exactly one cycle after sram_ren.
REQ-010 SHALL have ports o_valid  output  1, o_data  output  256, o_tag  output  4, o_first  output  1, o_last  output  1, i_ready  input  1: outbound beat stream.
REQ-011 SHALL have ports o_err_cnt  output  8  saturating drop counter; o_busy  output  1  high when FIFO non-empty or a message is in progress.

Function
REQ-012 SHALL push {tag,addr,len} into the descriptor FIFO when evt_valid is high and the event is not rejected.
REQ-013 SHALL reject (drop, increment o_err_cnt) events with evt_len == 0, evt_len > MAX_LEN, or FIFO full with no pop in the same cycle; push at full with same-cycle pop SHALL be accepted.
REQ-014 SHALL saturate o_err_cnt at 8'hFF; multiple reject causes in one event count once.
REQ-015 SHALL implement FSM IDLE -> FETCH -> DRAIN -> IDLE.
REQ-016 IDLE: when FIFO non-empty, pop head, load rd_addr, remaining = len, cur_tag; go FETCH next cycle.
REQ-017 FETCH: assert sram_ren with sram_raddr = rd_addr when buffer occupancy (after this cycle's output pop) plus in-flight reads < 2; on issue increment rd_addr modulo 1024 (1023 wraps to 0) and decrement remaining; after last issue go DRAIN.
REQ-018 DRAIN: wait until in-flight read returned and output buffer empty of the message's last beat, then IDLE; IDLE-to-FETCH of next descriptor SHALL take one cycle.
REQ-019 SHALL capture sram_rdata one cycle after each sram_ren into a 2-entry output buffer; no beat SHALL ever be lost or duplicated under any i_ready pattern.
REQ-020 SHALL transfer a beat when o_valid && i_ready; o_data/o_tag/o_first/o_last SHALL hold stable while o_valid && !i_ready.
REQ-021 o_first SHALL be high on beat 0 and o_last on beat len-1 of each message; both high for len == 1.
REQ-022 With i_ready held high SHALL sustain one beat per cycle; first beat latency from evt_valid to o_valid SHALL be 3 cycles with an empty FIFO and idle FSM.
REQ-023 Messages SHALL be emitted in event order, never interleaved.

Reset
REQ-024 While rst is high at a clock edge: FSM = IDLE, FIFO empty, output buffer empty, in-flight count 0, o_err_cnt = 0.
REQ-025 Outputs after reset: sram_ren = 0, sram_raddr = 0, o_valid = 0, o_data = 0, o_tag = 0, o_first = 0, o_last = 0, o_busy = 0.
REQ-026 Reset mid-message SHALL abandon it; SRAM data returning the cycle after reset SHALL be discarded; evt_valid during reset SHALL be ignored.

Configuration
REQ-027 With macro PCIE_MSG_FETCH_TAG_CHECK_EN defined, an event whose tag equals a tag in the FIFO or the in-progress message SHALL be rejected and counted in o_err_cnt.
REQ-028 Without PCIE_MSG_FETCH_TAG_CHECK_EN, duplicate tags SHALL be accepted normally and no comparison logic SHALL exist.

Verification
REQ-029 Event tag 3, addr 10, len 4, i_ready=1 -> o_valid from cycle 3, four beats = SRAM[10..13], o_first beat 0, o_last beat 3, o_tag 3.
REQ-030 Event addr 1022, len 4 -> beats SRAM[1022], [1023], [0], [1] in order.
REQ-031 Six back-to-back events, DESC_DEPTH=4, FSM busy -> o_err_cnt=1 or 2 per pops occurred, accepted messages output in order, no beat gaps when i_ready=1.
REQ-032 len 8, i_ready toggled 1,0,0,1 repeating -> exactly 8 beats, each held stable while stalled, data matches SRAM.
REQ-033 Events len 0 and len 1025 -> o_err_cnt=2, no output, o_busy stays 0.
REQ-034 rst asserted mid-message at beat 2 of 6 -> next cycle o_valid=0, o_err_cnt=0; fresh event afterwards fully correct; with PCIE_MSG_FETCH_TAG_CHECK_EN, two events tag 5 queued -> second dropped, o_err_cnt=1.
